// File: rtl/conv3_pkg.sv
// conv3_pkg: shared FSM type, lane count and fixed-point helpers for conv3_pair_mac
// Contents: state_t (IDLE/LOAD/RUN/DONE), LANES, lane() extractor, rescale() round/saturate.
package conv3_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam int LANES = 9;
    localparam int XW = 64;
    // Lane k of an MSB-first packed word, returned in the low dw bits.
    function automatic logic [XW-1:0] lane(input logic [LANES*XW-1:0] w, input int k, input int dw);
        return XW'(w >> (dw * (LANES - 1 - k)));
    endfunction
    // Round-half-up arithmetic shift by frac, then clamp to a signed dw-bit range.
    function automatic logic [XW-1:0] rescale(input logic signed [XW-1:0] v, input int frac, input int dw);
        logic signed [XW-1:0] r, hi, lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        r = (v + (64'sd1 <<< (frac - 1))) >>> frac;
        return (r > hi) ? hi : ((r < lo) ? lo : r);
    endfunction
endpackage

// File: rtl/conv3_pair_mac_dot9.sv
// conv3_dot9: combinational 9-lane signed multiply and sum of a window against a kernel word
// Ports: x (window, element 0 in MSBs), w (kernel word, lane 0 in MSBs), sum (ACC_W signed).
module conv3_dot9
    import conv3_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic [LANES*DATA_W-1:0] x,
    input  logic [LANES*DATA_W-1:0] w,
    output logic signed [ACC_W-1:0] sum
);
    logic signed [DATA_W-1:0] xs [LANES];
    logic signed [DATA_W-1:0] ws [LANES];
    logic signed [2*DATA_W-1:0] prod [LANES];
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign xs[k] = DATA_W'(lane((LANES*XW)'(x), k, DATA_W));
        assign ws[k] = DATA_W'(lane((LANES*XW)'(w), k, DATA_W));
        assign prod[k] = (2*DATA_W)'(xs[k]) * (2*DATA_W)'(ws[k]);
    end
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) sum = sum + ACC_W'(prod[i]);
    end
endmodule

// File: rtl/conv3_pair_mac.sv
// conv3_pair_mac: 3x3 conv MAC fetching an even/odd output-channel kernel pair per cycle from a dual-port ROM
// Ports: clk, rst (async, active-high); win_valid/win_ready/win_data window input stream;
//        addr_a/addr_b ROM addresses, q_a/q_b ROM data (one cycle later);
//        out_valid/out_ready/out_a/out_b/out_pair result stream; busy (not IDLE).
// Optional: define CONV3_PAIR_MAC_RELU_EN to clamp negative results to zero.
module conv3_pair_mac
    import conv3_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 76,
    parameter int DATA_W     = 16,
    parameter int NUM_IN_CH  = 2,
    parameter int FRAC_BITS  = 12,
    parameter int ACC_W      = 40,
    localparam int NP  = DEPTH / (2 * NUM_IN_CH),
    localparam int PW  = $clog2(NP),
    localparam int ICW = (NUM_IN_CH > 1) ? $clog2(NUM_IN_CH) : 1,
    localparam int WW  = LANES * DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  win_valid,
    output logic                  win_ready,
    input  logic [WW-1:0]         win_data,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [WW-1:0]         q_a,
    input  logic [WW-1:0]         q_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic [PW-1:0]         out_pair,
    output logic                  busy
);
    state_t state, nxt;
    logic [WW-1:0] win_buf [NUM_IN_CH];
    logic [ICW-1:0] ld_cnt, ic, tag_ic, wr_idx;
    logic [PW-1:0] p, tag_p;
    logic tag_v, tag_last, take, last_beat, last_ic, hold, issue;
    logic signed [ACC_W-1:0] acc_a, acc_b, dot_a, dot_b, sum_a, sum_b;
    logic [DATA_W-1:0] sat_a, sat_b, res_a, res_b;

    assign take = win_valid && win_ready;
    assign wr_idx = state == IDLE ? '0 : ld_cnt;
    assign last_beat = state == IDLE ? (NUM_IN_CH == 1) : (ld_cnt == ICW'(NUM_IN_CH - 1));
    assign last_ic = ic == ICW'(NUM_IN_CH - 1);
    // A pair's final issue waits while the output register is occupied or about to be written.
    assign hold = last_ic && ((out_valid && !out_ready) || (tag_v && tag_last));
    assign issue = state == RUN && !hold;
    assign busy = state != IDLE;
    assign addr_a = state == RUN ? ADDR_WIDTH'(2 * int'(p) * NUM_IN_CH + int'(ic)) : '0;
    assign addr_b = state == RUN ? ADDR_WIDTH'((2 * int'(p) + 1) * NUM_IN_CH + int'(ic)) : '0;

    always_comb begin
        nxt = state;
        if ((state == IDLE || state == LOAD) && take && last_beat) nxt = RUN;
        else if (state == IDLE && take) nxt = LOAD;
        else if (issue && last_ic && p == PW'(NP - 1)) nxt = DONE;
        else if (state == DONE && out_valid && out_ready && !tag_v) nxt = IDLE;
    end

    conv3_dot9 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_dot_a (.x(win_buf[tag_ic]), .w(q_a), .sum(dot_a));
    conv3_dot9 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_dot_b (.x(win_buf[tag_ic]), .w(q_b), .sum(dot_b));

    assign sum_a = (tag_ic == '0 ? '0 : acc_a) + dot_a;
    assign sum_b = (tag_ic == '0 ? '0 : acc_b) + dot_b;
    assign sat_a = DATA_W'(rescale(64'(sum_a), FRAC_BITS, DATA_W));
    assign sat_b = DATA_W'(rescale(64'(sum_b), FRAC_BITS, DATA_W));
`ifdef CONV3_PAIR_MAC_RELU_EN
    assign res_a = sat_a[DATA_W-1] ? '0 : sat_a;
    assign res_b = sat_b[DATA_W-1] ? '0 : sat_b;
`else
    assign res_a = sat_a;
    assign res_b = sat_b;
`endif

    always_ff @(posedge clk) begin
        if (take) win_buf[wr_idx] <= win_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_ready <= 1'b0;
            ld_cnt    <= '0;
            p         <= '0;
            ic        <= '0;
            tag_v     <= 1'b0;
            tag_last  <= 1'b0;
            tag_ic    <= '0;
            tag_p     <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_pair  <= '0;
        end else begin
            state     <= nxt;
            win_ready <= nxt == IDLE || nxt == LOAD;
            if (take) ld_cnt <= state == IDLE ? ICW'(1) : ld_cnt + 1'b1;
            if (issue) begin
                ic <= last_ic ? '0 : ic + 1'b1;
                p  <= !last_ic ? p : (p == PW'(NP - 1) ? '0 : p + 1'b1);
            end
            tag_v    <= issue;
            tag_ic   <= ic;
            tag_last <= last_ic;
            tag_p    <= p;
            if (tag_v && !tag_last) begin
                acc_a <= sum_a;
                acc_b <= sum_b;
            end
            if (tag_v && tag_last) begin
                out_a    <= res_a;
                out_b    <= res_b;
                out_pair <= tag_p;
            end
            out_valid <= (tag_v && tag_last) || (out_valid && !out_ready);
        end
    end
endmodule
